// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: packs signed real samples into complex FFT input words
// and cuts them into frames of FRAME_LEN words. The frame boundary is marked
// with o_data_last. A flush request closes a partial frame by appending
// zero words up to the end of the frame.
module fft_frame_feeder #(
  parameter int FRAME_LEN = 1024,
  parameter int SAMPLE_W  = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_data_valid,
  input  logic [SAMPLE_W-1:0] i_data,
  output logic                o_data_ready,
  input  logic                i_flush,
  output logic                o_data_valid,
  output logic [31:0]         o_data,
  output logic                o_data_last,
  input  logic                i_data_ready,
  output logic [15:0]         o_frame_count,
  output logic                o_padding
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_PAD = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_wcnt;
  logic [CNT_W-1:0]  w_wcnt_next;
  logic              r_valid;
  logic              r_last;
  logic              r_padding;
  logic [31:0]       r_data;
  logic [15:0]       r_frame_count;

  logic              w_load;
  logic              w_accept;
  logic              w_word_load;
  logic              w_word_last;
  logic [31:0]       w_word;
  logic signed [15:0] w_sample_ext;

  // The output register can take a new word when empty or being drained.
  assign w_load       = !r_valid || i_data_ready;
  // Ready is gated by reset so nothing is accepted while reset is held.
  assign o_data_ready = !i_rst && (r_state == ST_RUN) && w_load;
  assign w_accept     = o_data_ready && i_data_valid;
  assign w_sample_ext = 16'($signed(i_data));

  assign o_data_valid  = r_valid;
  assign o_data        = r_data;
  assign o_data_last   = r_last;
  assign o_frame_count = r_frame_count;
  assign o_padding     = r_padding;

  // Select the next word, its frame position and the next FSM state.
  always_comb begin
    w_word_load  = 1'b0;
    w_word       = 32'h0000_0000;
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        w_word_load = w_accept;
        w_word      = {16'h0000, w_sample_ext};
      end
      ST_PAD: begin
        w_word_load = w_load;
        w_word      = 32'h0000_0000;
      end
      default: begin
        w_word_load = 1'b0;
        w_word      = 32'h0000_0000;
      end
    endcase

    w_word_last = w_word_load && (r_wcnt == LAST_IDX);

    if (w_word_load) begin
      w_wcnt_next = r_wcnt + CNT_ONE;
    end else begin
      w_wcnt_next = r_wcnt;
    end

    // A flush only matters if the frame (including a same-cycle sample)
    // is partially filled; flush requests are ignored while padding.
    case (r_state)
      ST_RUN: begin
        if (i_flush && (w_wcnt_next != CNT_ZERO)) begin
          w_state_next = ST_PAD;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_PAD: begin
        if (w_word_last) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_PAD;
        end
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // FSM, word counter, frame counter and the single output register stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_RUN;
      r_padding     <= 1'b0;
      r_wcnt        <= CNT_ZERO;
      r_valid       <= 1'b0;
      r_last        <= 1'b0;
      r_data        <= 32'h0000_0000;
      r_frame_count <= 16'h0000;
    end else begin
      r_state   <= w_state_next;
      r_padding <= (w_state_next == ST_PAD);
      r_wcnt    <= w_wcnt_next;
      if (w_word_load) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
        r_last  <= w_word_last;
      end else if (i_data_ready) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else begin
        r_valid <= r_valid;
        r_last  <= r_last;
      end
      if (w_word_last) begin
        r_frame_count <= r_frame_count + 16'h0001;
      end else begin
        r_frame_count <= r_frame_count;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Self-checking bench for fft_frame_feeder with FRAME_LEN=8. A reference
// model runs on the falling edge, pushes expected words into a scoreboard
// when they are loaded and pops them when the DUT hands them downstream.
module tb_fft_frame_feeder;

  localparam int FL = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        dv;
  logic [15:0] din;
  logic        flush;
  logic        rdy;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_data;
  logic        o_last;
  logic [15:0] o_fc;
  logic        o_pad;

  logic        v12;
  logic [11:0] d12;
  logic        o12_ready;
  logic        o12_valid;
  logic [31:0] o12_data;
  logic        o12_last;
  logic [15:0] o12_fc;
  logic        o12_pad;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  fft_frame_feeder #(.FRAME_LEN(FL), .SAMPLE_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_data_valid(dv), .i_data(din),
    .o_data_ready(o_ready), .i_flush(flush), .o_data_valid(o_valid),
    .o_data(o_data), .o_data_last(o_last), .i_data_ready(rdy),
    .o_frame_count(o_fc), .o_padding(o_pad)
  );

  fft_frame_feeder #(.FRAME_LEN(FL), .SAMPLE_W(12)) dut12 (
    .i_clk(clk), .i_rst(rst), .i_data_valid(v12), .i_data(d12),
    .o_data_ready(o12_ready), .i_flush(1'b0), .o_data_valid(o12_valid),
    .o_data(o12_data), .o_data_last(o12_last), .i_data_ready(1'b1),
    .o_frame_count(o12_fc), .o_padding(o12_pad)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [32:0] sbq[$];
  int          m_wcnt = 0;
  bit          m_pad = 1'b0;
  bit          m_valid = 1'b0;
  int          m_frames = 0;
  int          pad_cycles = 0;
  bit          was_stall = 1'b0;
  logic [31:0] held_data;
  logic        held_last;

  always @(negedge clk) begin
    logic [32:0] e;
    bit          exp_ready;
    bit          do_load;
    bit          wl;
    bit          orig_pad;
    logic [31:0] word;
    if (rst) begin
      chk("rst_ready", 32'(o_ready), 32'd0);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_data", o_data, 32'd0);
      chk("rst_last", 32'(o_last), 32'd0);
      chk("rst_fc", 32'(o_fc), 32'd0);
      chk("rst_pad", 32'(o_pad), 32'd0);
      sbq.delete();
      m_wcnt = 0; m_pad = 1'b0; m_valid = 1'b0; m_frames = 0; was_stall = 1'b0;
    end else begin
      exp_ready = !m_pad && (!m_valid || rdy);
      chk("ready", 32'(o_ready), 32'(exp_ready));
      chk("valid", 32'(o_valid), 32'(m_valid));
      chk("padding", 32'(o_pad), 32'(m_pad));
      chk("frame_count", 32'(o_fc), 32'(m_frames % 65536));
      if (m_pad) pad_cycles++;
      if (was_stall) begin
        chk("stall_data", o_data, held_data);
        chk("stall_last", 32'(o_last), 32'(held_last));
      end
      was_stall = m_valid && !rdy;
      held_data = o_data;
      held_last = o_last;
      if (m_valid && rdy) begin
        chk("sb_nonempty", 32'(sbq.size() > 0), 32'd1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("out_data", o_data, e[31:0]);
          chk("out_last", 32'(o_last), 32'(e[32]));
        end
      end
      orig_pad = m_pad;
      do_load = 1'b0;
      word = 32'd0;
      if (!orig_pad) begin
        if (dv && exp_ready) begin
          do_load = 1'b1;
          word = {{16{din[15]}}, din} & 32'h0000_FFFF;
        end
      end else if (!m_valid || rdy) begin
        do_load = 1'b1;
      end
      wl = do_load && (m_wcnt == FL - 1);
      if (do_load) begin
        sbq.push_back({wl, word});
        if (wl) m_frames++;
        m_wcnt = (m_wcnt + 1) % FL;
      end
      if (!orig_pad && flush && m_wcnt != 0) m_pad = 1'b1;
      else if (orig_pad && wl) m_pad = 1'b0;
      m_valid = do_load ? 1'b1 : (rdy ? 1'b0 : m_valid);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] d, input bit rnd, input bit fl);
    int guard = 0;
    bit acc = 1'b0;
    dv = 1'b1; din = d; flush = fl;
    do begin
      if (rnd) rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      flush = 1'b0;
      guard++;
    end while (!acc && guard < 200);
    chk("send_accept", 32'(acc), 32'd1);
    dv = 1'b0;
  endtask

  task automatic drain();
    rdy = 1'b1;
    step(12);
    chk("drain_empty", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    int c0;
    rst = 1'b1; dv = 1'b0; din = 16'h0000; flush = 1'b0; rdy = 1'b1;
    v12 = 1'b0; d12 = 12'h000;
    step(2);
    rst = 1'b0;

    // 16 back-to-back samples: two frames, one word per cycle
    c0 = cyc;
    for (int i = 1; i <= 16; i++) send(16'(i), 1'b0, 1'b0);
    chk("b2b_cycles", 32'(cyc - c0), 32'd16);
    drain();
    chk("frames_after_16", 32'(o_fc), 32'd2);

    // Sign extension plus a 3-sample partial frame closed by flush
    send(16'h8000, 1'b0, 1'b0);
    send(16'h7FFF, 1'b0, 1'b0);
    send(16'hFFFF, 1'b0, 1'b0);
    step(2);
    pad_cycles = 0;
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(10);
    chk("pad_cycles", 32'(pad_cycles), 32'd5);
    chk("frames_after_pad", 32'(o_fc), 32'd3);

    // 12-bit sample width sign extension
    v12 = 1'b1; d12 = 12'h800;
    step(1);
    d12 = 12'h7FF;
    @(negedge clk);
    chk("sext12_neg", o12_data, 32'h0000_F800);
    chk("sext12_valid", 32'(o12_valid), 32'd1);
    step(1);
    v12 = 1'b0;
    @(negedge clk);
    chk("sext12_pos", o12_data, 32'h0000_07FF);
    step(1);

    // Flush coincident with the 8th sample closes the frame without padding
    pad_cycles = 0;
    for (int i = 0; i < 7; i++) send(16'(16'h0100 + i), 1'b0, 1'b0);
    send(16'h0200, 1'b0, 1'b1);
    step(4);
    chk("no_pad_full", 32'(pad_cycles), 32'd0);
    chk("frames_full_flush", 32'(o_fc), 32'd4);
    // Flush at a frame boundary does nothing
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(3);
    chk("no_pad_wcnt0", 32'(pad_cycles), 32'd0);
    chk("pad_flag_wcnt0", 32'(o_pad), 32'd0);

    // Random downstream backpressure over 64 samples
    for (int i = 0; i < 64; i++) send(16'($urandom), 1'b1, 1'b0);
    drain();
    chk("frames_random", 32'(o_fc), 32'd12);

    // Reset mid-frame discards the partial frame
    for (int i = 0; i < 5; i++) send(16'(16'h0300 + i), 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(o_valid), 32'd0);
    chk("rst_async_data", o_data, 32'd0);
    chk("rst_async_fc", 32'(o_fc), 32'd0);
    step(1);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) send(16'(16'h0400 + i), 1'b0, 1'b0);
    drain();
    chk("frames_after_rst", 32'(o_fc), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fft_frame_feeder.md
FFT_FRAME_FEEDER -- requirements
Module: fft_frame_feeder

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 1024, meaning the number of complex words per FFT frame (power of two, 8..65536).
REQ-002 SHALL have parameter SAMPLE_W, default 16, meaning the signed real sample width (at most 16).
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state on rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port i_data_valid, input, 1 bit: upstream sample valid.
REQ-006 SHALL have port i_data, input, SAMPLE_W bits: signed real sample.
REQ-007 SHALL have port o_data_ready, output, 1 bit: sample accepted when high with i_data_valid.
REQ-008 SHALL have port i_flush, input, 1 bit: single-cycle request to zero-pad and close the current partial frame.
REQ-009 SHALL have port o_data_valid, output, 1 bit: FFT input word valid.
REQ-010 SHALL have port o_data, output, 32 bits: complex word, [31:16] imaginary, [15:0] real.
REQ-011 SHALL have port o_data_last, output, 1 bit: marks the final word of a frame (tlast).
REQ-012 SHALL have port i_data_ready, input, 1 bit: FFT input ready.
REQ-013 SHALL have port o_frame_count, output, 16 bits: completed frames, wraps at 16'hFFFF->0.
REQ-014 SHALL have port o_padding, output, 1 bit: high while in PAD state.

Function
REQ-015 SHALL hold one output register stage (o_data, o_data_valid, o_data_last), loaded when load = !o_data_valid || i_data_ready.
REQ-016 SHALL clear o_data_valid on a cycle where i_data_ready is high and no new word loads.
REQ-017 SHALL implement states RUN and PAD.
REQ-018 SHALL drive o_data_ready = (state==RUN) && load, combinationally; i_data_ready->o_data_ready path is permitted.
REQ-019 SHALL, in RUN, on accept, load o_data = {16'h0000, sign-extended i_data to 16 bits}, zero-latency-to-register (word visible the cycle after accept).
REQ-020 SHALL keep word counter wcnt (0..FRAME_LEN-1), incrementing on every loaded word, wrapping to 0 after FRAME_LEN-1.
REQ-021 SHALL set o_data_last with the loaded word when wcnt==FRAME_LEN-1, and increment o_frame_count on that load.
REQ-022 SHALL, in RUN, on i_flush, move to PAD when post-cycle wcnt != 0 (a sample accepted in the same cycle counts in the frame).
REQ-023 SHALL ignore i_flush when post-cycle wcnt == 0, and ignore it entirely while in PAD.
REQ-024 SHALL, in PAD, load 32'h00000000 on every load cycle, with o_data_ready low.
REQ-025 SHALL return from PAD to RUN on the cycle the padded word with o_data_last=1 is loaded.
REQ-026 SHALL never drop or duplicate a sample: stall (i_data_ready low) holds o_data, o_data_valid, o_data_last stable.
REQ-027 SHALL assert o_padding exactly while state==PAD.

Reset
REQ-028 SHALL, while i_rst is high, force: state=RUN, wcnt=0, o_data_valid=0, o_data=0, o_data_last=0, o_frame_count=0, o_padding=0, o_data_ready=0.
REQ-029 SHALL, on reset mid-frame or mid-PAD, discard the partial frame with no o_data_last emitted.
REQ-030 SHALL accept data from the first clock edge after i_rst deasserts.

Verification (FRAME_LEN=8)
REQ-031 SHALL verify: 16 back-to-back samples 1..16, i_data_ready=1 -> 16 words, one per cycle, o_data_last on words 8 and 16, o_frame_count=2.
REQ-032 SHALL verify: sample 16'h8000 -> o_data=32'h00008000; with SAMPLE_W=12, 12'h800 -> 32'h0000F800.
REQ-033 SHALL verify: 3 samples then i_flush -> 5 words 32'h0 follow, last one with o_data_last, o_padding high 5 cycles (ready=1), o_data_ready low throughout PAD.
REQ-034 SHALL verify: i_flush coincident with accepting the 8th sample -> no PAD, o_frame_count=1; i_flush with wcnt=0 -> no effect.
REQ-035 SHALL verify: random i_data_ready toggling (50%) over 64 samples -> output sequence equals input sequence, o_data held stable during stalls, o_frame_count=8.
REQ-036 SHALL verify: i_rst pulse after 5 samples -> outputs zero, next 8 samples form a complete frame with o_data_last on the 8th.
